// File: rtl/lfsr_pkg.sv
// Shared definitions for the LFSR test controller, generator and checker:
// state encodings, the state type and the default (non-zero) seed.
package lfsr_pkg;

  localparam logic [2:0] STATE_IDLE    = 3'd0;
  localparam logic [2:0] STATE_SEED    = 3'd1;
  localparam logic [2:0] STATE_ACQUIRE = 3'd2;
  localparam logic [2:0] STATE_TRACK   = 3'd3;
  localparam logic [2:0] STATE_FAIL    = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE    = STATE_IDLE,
    ST_SEED    = STATE_SEED,
    ST_ACQUIRE = STATE_ACQUIRE,
    ST_TRACK   = STATE_TRACK,
    ST_FAIL    = STATE_FAIL
  } lfsr_state_e;

  localparam logic [7:0] SEED_DEFAULT = 8'h01;

  // An all-zero seed would lock the LFSR, so it is replaced by the default.
  function automatic logic [7:0] fix_seed(input logic [7:0] seed);
    return (seed == '0) ? SEED_DEFAULT : seed;
  endfunction

endpackage

// File: rtl/lfsr_beat_timer.sv
// Valid-beat period counter: a registered tick every VALID_PERIOD run cycles.
// The counter freezes while i_run is low and restarts from zero on i_clear.
module lfsr_beat_timer #(
  parameter int unsigned VALID_PERIOD = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_tick
);

  localparam int unsigned CW = $clog2(VALID_PERIOD + 1);
  localparam logic [CW-1:0] LAST = CW'(VALID_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // i_run/i_clear describe the upcoming cycle, so the tick lands in the
  // cycle it belongs to while still coming straight from a flop.
  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_run) begin
      tick_d = (cnt_q == LAST);
      cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign o_tick = tick_q;

endmodule

// File: rtl/lfsr_test_ctrl.sv
// LFSR test-run controller: seeds generator/checker, strobes valid beats,
// waits for checker lock and tracks lock losses. Optional error injection
// is enabled with `define LFSR_TEST_CTRL_ERR_INJ_EN.
module lfsr_test_ctrl
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_TIMEOUT = 64,
  parameter int unsigned VALID_PERIOD = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic [7:0] i_seed,
  input  logic       i_lock,
  output logic       o_seed_load,
  output logic [7:0] o_seed,
  output logic       o_chk_clear,
  output logic       o_valid,
  output logic       o_busy,
  output logic       o_locked,
  output logic       o_timeout,
  output logic [7:0] o_loss_cnt,
  output logic [2:0] o_state
`ifdef LFSR_TEST_CTRL_ERR_INJ_EN
  ,
  input  logic       i_inject,
  output logic       o_corrupt
`endif
);

  localparam int unsigned BW = $clog2(LOCK_TIMEOUT + 1);

  lfsr_state_e   state_q, state_d;
  logic [7:0]    seed_q, seed_d;
  logic [7:0]    loss_q, loss_d;
  logic [BW-1:0] beat_q, beat_d, beat_inc;
  logic          seed_load_q, chk_clear_q, busy_q, locked_q, timeout_q;
  logic          run_d, valid_w;

  assign beat_inc = beat_q + BW'(valid_w);

  always_comb begin
    state_d = state_q;
    seed_d  = seed_q;
    loss_d  = loss_q;
    if (i_stop) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:    if (i_start) state_d = ST_SEED;
        ST_SEED:    state_d = ST_ACQUIRE;
        ST_ACQUIRE: begin
          if (i_lock)                              state_d = ST_TRACK;
          else if (beat_inc >= BW'(LOCK_TIMEOUT))  state_d = ST_FAIL;
        end
        ST_TRACK: begin
          if (!i_lock) begin
            state_d = ST_ACQUIRE;
            if (loss_q != '1) loss_d = loss_q + 8'd1;
          end
        end
        ST_FAIL:    if (i_start) state_d = ST_SEED;
        default:    state_d = ST_IDLE;
      endcase
    end
    beat_d = (state_q == ST_ACQUIRE && state_d == ST_ACQUIRE) ? beat_inc : '0;
    if (state_d == ST_SEED) begin
      seed_d = fix_seed(i_seed);
      loss_d = '0;
    end
  end

  assign run_d = (state_d == ST_ACQUIRE) || (state_d == ST_TRACK);

  lfsr_beat_timer #(
    .VALID_PERIOD(VALID_PERIOD)
  ) u_beat_timer (
    .clk    (clk),
    .reset  (reset),
    .i_run  (run_d),
    .i_clear(state_d == ST_SEED),
    .o_tick (valid_w)
  );

  // Status flags are decoded from the next state so they change together
  // with o_state rather than a cycle behind it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      seed_q      <= SEED_DEFAULT;
      loss_q      <= '0;
      beat_q      <= '0;
      seed_load_q <= 1'b0;
      chk_clear_q <= 1'b0;
      busy_q      <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seed_q      <= seed_d;
      loss_q      <= loss_d;
      beat_q      <= beat_d;
      seed_load_q <= (state_d == ST_SEED);
      chk_clear_q <= (state_d == ST_SEED);
      busy_q      <= run_d || (state_d == ST_SEED);
      locked_q    <= (state_d == ST_TRACK);
      timeout_q   <= (state_d == ST_FAIL);
    end
  end

  assign o_seed_load = seed_load_q;
  assign o_seed      = seed_q;
  assign o_chk_clear = chk_clear_q;
  assign o_valid     = valid_w;
  assign o_busy      = busy_q;
  assign o_locked    = locked_q;
  assign o_timeout   = timeout_q;
  assign o_loss_cnt  = loss_q;
  assign o_state     = state_q;

`ifdef LFSR_TEST_CTRL_ERR_INJ_EN
  logic inj_prev_q, pend_q, pend_d;

  always_comb begin
    pend_d = pend_q;
    if (valid_w && pend_q) pend_d = 1'b0;
    if (i_inject && !inj_prev_q && state_q == ST_TRACK && !pend_q) pend_d = 1'b1;
    if (!run_d) pend_d = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inj_prev_q <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      inj_prev_q <= i_inject;
      pend_q     <= pend_d;
    end
  end

  // Both terms are flops, so the marker stays aligned with its valid beat.
  assign o_corrupt = valid_w && pend_q;
`endif

endmodule
